// File: rtl/cond_exec_unit.sv
// Conditional-execution stage: holds NZCV, evaluates the ARM condition field and
// gates the control FSM's raw write requests into real PC/regfile/memory enables.
module cond_exec_unit #(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       NextPC,
  input  logic       Branch,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  logic [3:0] flags_q;
  logic       cond_ex_reg;
  logic       flag_n, flag_z, flag_c, flag_v;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // Decode uses only the stored flags so the result never depends on this cycle's ALU.
  always_comb begin
    CondEx = 1'b0;
    case (cond_e'(Cond))
      EQ:      CondEx = flag_z;
      NE:      CondEx = ~flag_z;
      CS:      CondEx = flag_c;
      CC:      CondEx = ~flag_c;
      MI:      CondEx = flag_n;
      PL:      CondEx = ~flag_n;
      VS:      CondEx = flag_v;
      VC:      CondEx = ~flag_v;
      HI:      CondEx = flag_c & ~flag_z;
      LS:      CondEx = ~flag_c | flag_z;
      GE:      CondEx = (flag_n == flag_v);
      LT:      CondEx = (flag_n != flag_v);
      GT:      CondEx = ~flag_z & (flag_n == flag_v);
      LE:      CondEx = flag_z | (flag_n != flag_v);
      AL:      CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

  // Each flag half is written only when requested, so X on an unused ALUFlags half is never sampled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q     <= FLAGS_RST;
      cond_ex_reg <= 1'b0;
    end else begin
      cond_ex_reg <= CondEx;
      if (FlagW[1] && CondEx) flags_q[3:2] <= ALUFlags[3:2];
      if (FlagW[0] && CondEx) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  // Registered condition keeps a multicycle instruction from cancelling its own writeback.
  assign PCWrite  = reset & (NextPC | (Branch & cond_ex_reg));
  assign RegWrite = reset & RegW & cond_ex_reg;
  assign MemWrite = reset & MemW & cond_ex_reg;
  assign Flags    = flags_q;

endmodule

// File: tb/tb_cond_exec_unit.sv
// Directed self-checking bench for cond_exec_unit: reset, flag writes, condition
// decode table, write gating and same-instruction flag timing.
module tb_cond_exec_unit;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       NextPC, Branch, RegW, MemW;
  logic       PCWrite, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;

  int compared = 0;
  int mismatched = 0;

  cond_exec_unit #(.FLAGS_RST(4'b0000)) dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .NextPC   (NextPC),
    .Branch   (Branch),
    .RegW     (RegW),
    .MemW     (MemW),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
    .Flags    (Flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw,
                               input logic np, input logic br, input logic rw, input logic mw);
    Cond = c; ALUFlags = af; FlagW = fw;
    NextPC = np; Branch = br; RegW = rw; MemW = mw;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  logic [15:0] exp_tbl;

  initial begin
    reset = 1'b0;
    applyStimulus(4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(); tick();
    checkOutput("rst_pcwrite",  {3'b0, PCWrite},  4'b0000);
    checkOutput("rst_regwrite", {3'b0, RegWrite}, 4'b0000);
    checkOutput("rst_memwrite", {3'b0, MemWrite}, 4'b0000);
    checkOutput("rst_flags",    Flags,            4'b0000);

    // Flag writes under AL, then independent halves and an X on the unused half
    reset = 1'b1;
    applyStimulus(4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("flagw_11", Flags, 4'b0100);
    applyStimulus(4'b1110, 4'b1011, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("flagw_01", Flags, 4'b0111);
    applyStimulus(4'b1110, 4'b10xx, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("flagw_10_x", Flags, 4'b1011);

    // EQ with Z=1 then Z=0
    applyStimulus(4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("eq_z1_regwrite", {3'b0, RegWrite}, 4'b0001);
    checkOutput("eq_z1_memwrite", {3'b0, MemWrite}, 4'b0001);
    applyStimulus(4'b1110, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("eq_z0_regwrite", {3'b0, RegWrite}, 4'b0000);

    // Failed condition blocks flag write and later regfile write
    applyStimulus(4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0001, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ne_condex", {3'b0, CondEx}, 4'b0000);
    tick();
    applyStimulus(4'b0001, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("ne_flags_held", Flags, 4'b0100);
    checkOutput("ne_regwrite",   {3'b0, RegWrite}, 4'b0000);

    // GE branch gating, NextPC unconditional
    applyStimulus(4'b1110, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b1010, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("ge_nv10_pcwrite", {3'b0, PCWrite}, 4'b0000);
    applyStimulus(4'b1110, 4'b1001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b1010, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("ge_nv11_pcwrite", {3'b0, PCWrite}, 4'b0001);
    applyStimulus(4'b1010, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("nextpc_branch_pcwrite", {3'b0, PCWrite}, 4'b0001);

    // NV never executes: only NextPC gets through
    applyStimulus(4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("nv_condex", {3'b0, CondEx}, 4'b0000);
    tick();
    applyStimulus(4'b1111, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("nv_branch_pcwrite", {3'b0, PCWrite},  4'b0000);
    checkOutput("nv_regwrite",       {3'b0, RegWrite}, 4'b0000);
    checkOutput("nv_memwrite",       {3'b0, MemWrite}, 4'b0000);
    applyStimulus(4'b1111, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("nv_nextpc_pcwrite", {3'b0, PCWrite},  4'b0001);

    // Same instruction: flag update in EXECUTE does not cancel its own writeback
    applyStimulus(4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0000, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("same_instr_regwrite", {3'b0, RegWrite}, 4'b0001);
    checkOutput("same_instr_flags",    Flags,            4'b0000);
    checkOutput("same_instr_condex",   {3'b0, CondEx},   4'b0000);

    // Full decode table with N=1 Z=0 C=1 V=0
    applyStimulus(4'b1110, 4'b1010, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    exp_tbl = 16'b0110_1001_1001_0110;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(4'(i), 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("decode_1010_c%0d", i), {3'b0, CondEx}, {3'b0, exp_tbl[i]});
    end

    // Reset mid-instruction drops enables immediately, flags reload at the edge
    applyStimulus(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b1110, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("pre_rst_regwrite", {3'b0, RegWrite}, 4'b0001);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_pcwrite",  {3'b0, PCWrite},  4'b0000);
    checkOutput("mid_rst_regwrite", {3'b0, RegWrite}, 4'b0000);
    checkOutput("mid_rst_memwrite", {3'b0, MemWrite}, 4'b0000);
    checkOutput("mid_rst_flags_pre_edge", Flags, 4'b1010);
    tick();
    checkOutput("mid_rst_flags_post_edge", Flags, 4'b0000);
    reset = 1'b1;
    applyStimulus(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("post_rst_regwrite", {3'b0, RegWrite}, 4'b0000);

    // Full decode table with N=0 Z=1 C=0 V=1
    applyStimulus(4'b1110, 4'b0101, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    exp_tbl = 16'b0110_1010_0110_1001;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(4'(i), 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("decode_0101_c%0d", i), {3'b0, CondEx}, {3'b0, exp_tbl[i]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
